// File: rtl/fbw_stream_loader_if.sv
// Byte-stream input and hub75 frame-buffer write port bundled as one interface.
interface fbw_stream_loader_if #(
  parameter int unsigned N_ROWS = 64,
  parameter int unsigned N_COLS = 64
);
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS);
  localparam int unsigned LOG_N_COLS = $clog2(N_COLS);

  logic [7:0]            in_data;
  logic                  in_sof;
  logic                  in_valid;
  logic                  in_ready;
  logic [LOG_N_ROWS-1:0] fbw_row_addr;
  logic                  fbw_row_store;
  logic                  fbw_row_rdy;
  logic                  fbw_row_swap;
  logic [23:0]           fbw_data;
  logic [LOG_N_COLS-1:0] fbw_col_addr;
  logic                  fbw_wren;
  logic                  frame_swap;
  logic                  frame_rdy;
  logic                  resync_err;

  // Loader side: sinks the byte stream, drives the frame-buffer write port.
  modport slave (
    input  in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
    output in_ready, fbw_row_addr, fbw_row_store, fbw_row_swap,
           fbw_data, fbw_col_addr, fbw_wren, frame_swap, resync_err
  );

  // Environment side: byte source plus frame-buffer/display readiness.
  modport master (
    output in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
    input  in_ready, fbw_row_addr, fbw_row_store, fbw_row_swap,
           fbw_data, fbw_col_addr, fbw_wren, frame_swap, resync_err
  );
endinterface

// File: rtl/fbw_stream_loader.sv
// Packs an RGB888 byte stream into pixels and writes them into the hub75
// frame buffer row by row, committing rows and frames as they complete.
module fbw_stream_loader #(
  parameter int unsigned N_ROWS = 64,
  parameter int unsigned N_COLS = 64
) (
  input  logic                clk,
  input  logic                rst,
  fbw_stream_loader_if.slave  bus
);
  localparam int unsigned LOG_N_ROWS = $clog2(N_ROWS);
  localparam int unsigned LOG_N_COLS = $clog2(N_COLS);

  typedef enum logic [1:0] {LOAD, STORE, FRAME} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_byte, w_byte_nxt;
  logic [LOG_N_COLS-1:0] r_col, w_col_nxt;
  logic [LOG_N_ROWS-1:0] r_row, w_row_nxt;
  logic [7:0]            r_red, w_red_nxt;
  logic [7:0]            r_grn, w_grn_nxt;
  logic                  r_wren, w_wren_nxt;
  logic [23:0]           r_data, w_data_nxt;
  logic [LOG_N_COLS-1:0] r_col_addr, w_col_addr_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_in_ready, w_in_ready_nxt;
  logic                  w_accept;
  logic                  w_row_store;
  logic                  w_frame_swap;

  // in_ready is registered and high only in LOAD, so acceptance never depends
  // combinationally on in_valid feeding back into in_ready.
  assign w_accept = bus.in_valid & r_in_ready;

  // Next-state, counter and pixel-packing logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_nxt     = r_byte;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_red_nxt      = r_red;
    w_grn_nxt      = r_grn;
    w_wren_nxt     = 1'b0;
    w_data_nxt     = r_data;
    w_col_addr_nxt = r_col_addr;
    w_err_nxt      = r_err;
    w_row_store    = 1'b0;
    w_frame_swap   = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_accept) begin
          if (bus.in_sof) begin
            // Start-of-frame always restarts at pixel (0,0); any partial
            // progress is dropped and flagged.
            if ((r_byte != 2'd0) || (r_col != '0) || (r_row != '0)) begin
              w_err_nxt = 1'b1;
            end
            w_red_nxt  = bus.in_data;
            w_byte_nxt = 2'd1;
            w_col_nxt  = '0;
            w_row_nxt  = '0;
          end else begin
            case (r_byte)
              2'd0: begin
                w_red_nxt  = bus.in_data;
                w_byte_nxt = 2'd1;
              end
              2'd1: begin
                w_grn_nxt  = bus.in_data;
                w_byte_nxt = 2'd2;
              end
              default: begin
                w_wren_nxt     = 1'b1;
                w_data_nxt     = {bus.in_data, r_grn, r_red};
                w_col_addr_nxt = r_col;
                w_byte_nxt     = 2'd0;
                if (r_col == LOG_N_COLS'(N_COLS - 1)) begin
                  w_col_nxt   = '0;
                  w_state_nxt = STORE;
                end else begin
                  w_col_nxt = r_col + LOG_N_COLS'(1);
                end
              end
            endcase
          end
        end
      end
      STORE: begin
        // Waiting for !r_wren keeps the store strictly after the last write.
        if (bus.fbw_row_rdy && !r_wren) begin
          w_row_store = 1'b1;
          if (r_row == LOG_N_ROWS'(N_ROWS - 1)) begin
            w_state_nxt = FRAME;
          end else begin
            w_row_nxt   = r_row + LOG_N_ROWS'(1);
            w_state_nxt = LOAD;
          end
        end
      end
      FRAME: begin
        if (bus.frame_rdy) begin
          w_frame_swap = 1'b1;
          w_row_nxt    = '0;
          w_state_nxt  = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
    w_in_ready_nxt = (w_state_nxt == LOAD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOAD;
      r_byte     <= 2'd0;
      r_col      <= '0;
      r_row      <= '0;
      r_red      <= 8'd0;
      r_grn      <= 8'd0;
      r_wren     <= 1'b0;
      r_data     <= 24'd0;
      r_col_addr <= '0;
      r_err      <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_red      <= w_red_nxt;
      r_grn      <= w_grn_nxt;
      r_wren     <= w_wren_nxt;
      r_data     <= w_data_nxt;
      r_col_addr <= w_col_addr_nxt;
      r_err      <= w_err_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

  // Row address is the row counter itself, so it stays put through the store
  // pulse and advances on the edge that ends it.
  assign bus.in_ready      = r_in_ready;
  assign bus.fbw_row_addr  = r_row;
  assign bus.fbw_row_store = w_row_store;
  assign bus.fbw_row_swap  = w_row_store;
  assign bus.fbw_data      = r_data;
  assign bus.fbw_col_addr  = r_col_addr;
  assign bus.fbw_wren      = r_wren;
  assign bus.frame_swap    = w_frame_swap;
  assign bus.resync_err    = r_err;
endmodule

// File: tb/tb_fbw_stream_loader.sv
// Scoreboard bench for fbw_stream_loader with a 2x4 frame.
module tb_fbw_stream_loader;
  localparam int unsigned NR = 2;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fbw_stream_loader_if #(.N_ROWS(NR), .N_COLS(NC)) bus ();

  fbw_stream_loader #(.N_ROWS(NR), .N_COLS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic row_rdy_ctl, frame_rdy_ctl, rnd_mode;
  logic rnd_row_rdy, rnd_frame_rdy;
  assign bus.fbw_row_rdy = rnd_mode ? rnd_row_rdy   : row_rdy_ctl;
  assign bus.frame_rdy   = rnd_mode ? rnd_frame_rdy : frame_rdy_ctl;

  always @(posedge clk) begin
    rnd_row_rdy   <= ($urandom_range(0, 3) != 0);
    rnd_frame_rdy <= ($urandom_range(0, 2) == 0);
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model and scoreboard queues.
  int          m_byte, m_col, m_row;
  logic [7:0]  m_r, m_g;
  logic        exp_err;
  logic [39:0] wr_q[$];   // {row, col, data}
  int          st_q[$];
  int          fr_pend;
  logic [23:0] wr_log[$];
  int          st_log[$];
  int          fr_cnt;

  function automatic void model_reset();
    m_byte  = 0;
    m_col   = 0;
    m_row   = 0;
    exp_err = 1'b0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic sof);
    if (sof) begin
      if (m_byte != 0 || m_col != 0 || m_row != 0) exp_err = 1'b1;
      m_r = d; m_byte = 1; m_col = 0; m_row = 0;
    end else if (m_byte == 0) begin
      m_r = d; m_byte = 1;
    end else if (m_byte == 1) begin
      m_g = d; m_byte = 2;
    end else begin
      wr_q.push_back({8'(m_row), 8'(m_col), d, m_g, m_r});
      m_byte = 0;
      if (m_col == int'(NC) - 1) begin
        m_col = 0;
        st_q.push_back(m_row);
        if (m_row == int'(NR) - 1) begin
          m_row = 0;
          fr_pend++;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
  endfunction

  // Output monitor, sampled mid-cycle.
  logic [39:0] e;
  int          es;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fbw_wren) begin
        wr_log.push_back(bus.fbw_data);
        if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          check("wr_data", 32'(bus.fbw_data), 32'(e[23:0]));
          check("wr_col", 32'(bus.fbw_col_addr), 32'(e[31:24]));
          check("wr_row", 32'(bus.fbw_row_addr), 32'(e[39:32]));
        end
      end
      if (bus.fbw_row_store) begin
        st_log.push_back(int'(bus.fbw_row_addr));
        check("st_swap", 32'(bus.fbw_row_swap), 32'd1);
        check("st_inrdy", 32'(bus.in_ready), 32'd0);
        check("st_wren", 32'(bus.fbw_wren), 32'd0);
        if (st_q.size() == 0) check("st_unexpected", 32'd1, 32'd0);
        else begin
          es = st_q.pop_front();
          check("st_row", 32'(bus.fbw_row_addr), 32'(es));
        end
      end
      if (bus.frame_swap) begin
        fr_cnt++;
        check("fs_inrdy", 32'(bus.in_ready), 32'd0);
        if (fr_pend == 0) check("fs_unexpected", 32'd1, 32'd0);
        else fr_pend--;
      end
    end
  end

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_wren"}, 32'(bus.fbw_wren), 32'd0);
    check({pfx, "_store"}, 32'(bus.fbw_row_store), 32'd0);
    check({pfx, "_swap"}, 32'(bus.fbw_row_swap), 32'd0);
    check({pfx, "_fswap"}, 32'(bus.frame_swap), 32'd0);
    check({pfx, "_err"}, 32'(bus.resync_err), 32'd0);
    check({pfx, "_data"}, 32'(bus.fbw_data), 32'd0);
    check({pfx, "_col"}, 32'(bus.fbw_col_addr), 32'd0);
    check({pfx, "_row"}, 32'(bus.fbw_row_addr), 32'd0);
    check({pfx, "_inrdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte is taken.
  task automatic send_byte(input logic [7:0] d, input logic sof);
    int w;
    w = 0;
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      model_accept(d, sof);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  int st0, fr0;

  initial begin
    rst = 1'b1;
    bus.in_data = 8'd0; bus.in_sof = 1'b0; bus.in_valid = 1'b0;
    row_rdy_ctl = 1'b1; frame_rdy_ctl = 1'b1; rnd_mode = 1'b0;
    fr_pend = 0; fr_cnt = 0;
    model_reset();
    #1;
    check_reset_outs("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // One full frame, bytes 0x00..0x17.
    wr_log.delete(); st_log.delete(); fr_cnt = 0;
    for (int i = 0; i < 24; i++) send_byte(8'(i), i == 0);
    idle(6);
    check("ff_nwr", 32'(wr_log.size()), 32'd8);
    if (wr_log.size() == 8) begin
      check("ff_first", 32'(wr_log[0]), 32'h020100);
      check("ff_last", 32'(wr_log[7]), 32'h171615);
    end
    check("ff_nst", 32'(st_log.size()), 32'd2);
    if (st_log.size() == 2) begin
      check("ff_st0", 32'(st_log[0]), 32'd0);
      check("ff_st1", 32'(st_log[1]), 32'd1);
    end
    check("ff_nframe", 32'(fr_cnt), 32'd1);
    check("ff_err", 32'(bus.resync_err), 32'd0);

    // Row-store back-pressure.
    row_rdy_ctl = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'(8'h40 + i), 1'b0);
    st0 = st_log.size();
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("bp_inrdy", 32'(bus.in_ready), 32'd0);
      check("bp_store", 32'(bus.fbw_row_store), 32'd0);
    end
    check("bp_nostore", 32'(st_log.size()), 32'(st0));
    row_rdy_ctl = 1'b1;
    idle(2);
    check("bp_onestore", 32'(st_log.size()), 32'(st0 + 1));
    if (st_log.size() > 0) check("bp_strow", 32'(st_log[st_log.size() - 1]), 32'd0);

    // Frame-swap wait; row 1 writes checked against model.
    frame_rdy_ctl = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'(8'h60 + i), 1'b0);
    idle(2);
    fr0 = fr_cnt;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("fw_fswap", 32'(bus.frame_swap), 32'd0);
      check("fw_inrdy", 32'(bus.in_ready), 32'd0);
    end
    check("fw_noswap", 32'(fr_cnt), 32'(fr0));
    frame_rdy_ctl = 1'b1;
    idle(1);
    check("fw_swapped", 32'(fr_cnt), 32'(fr0 + 1));
    check("fw_row0", 32'(bus.fbw_row_addr), 32'd0);
    check("fw_inrdy_back", 32'(bus.in_ready), 32'd1);

    // Resync: sof mid-row.
    st0 = st_log.size();
    for (int i = 0; i < 7; i++) send_byte(8'(8'h80 + i), 1'b0);
    send_byte(8'hA0, 1'b1);
    check("rs_err", 32'(bus.resync_err), 32'd1);
    check("rs_err_model", 32'(bus.resync_err), 32'(exp_err));
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    idle(2);
    check("rs_nostore", 32'(st_log.size()), 32'(st0));
    if (wr_log.size() > 0) check("rs_pix", 32'(wr_log[wr_log.size() - 1]), 32'hA2A1A0);

    // Asynchronous reset in the middle of row 1.
    for (int i = 0; i < 13; i++) send_byte(8'(8'hC0 + i), 1'b0);
    idle(3);
    check("mr_row_before", 32'(bus.fbw_row_addr), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outs("mr");
    check("mr_wrq", 32'(wr_q.size()), 32'd0);
    check("mr_stq", 32'(st_q.size()), 32'd0);
    wr_q.delete(); st_q.delete(); fr_pend = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Three frames with random valid gaps and random readiness.
    rnd_mode = 1'b1;
    fr0 = fr_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 24; i++) begin
        idle($urandom_range(0, 2));
        send_byte(8'($urandom), i == 0);
      end
    end
    rnd_mode = 1'b0;
    idle(20);
    check("rnd_wrq", 32'(wr_q.size()), 32'd0);
    check("rnd_stq", 32'(st_q.size()), 32'd0);
    check("rnd_frpend", 32'(fr_pend), 32'd0);
    check("rnd_nframe", 32'(fr_cnt), 32'(fr0 + 3));
    check("rnd_err", 32'(bus.resync_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
